// File: rtl/health_beacon.sv
// Health beacon: polls N_SUB subsystems one at a time with a request/acknowledge
// handshake, pulses beat after every fully acknowledged round, and latches a
// sticky fault naming the first subsystem that failed to answer in time.
module health_beacon #(
  parameter int N_SUB       = 4,
  parameter int ACK_TIMEOUT = 1000,
  parameter int BEAT_PERIOD = 24000000,
  localparam int IW         = (N_SUB > 1) ? $clog2(N_SUB) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_SUB-1:0] ack,
  output logic [N_SUB-1:0] req,
  output logic             beat,
  output logic             ok,
  output logic             fail,
  output logic [IW-1:0]    fail_idx
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(BEAT_PERIOD + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_SUB - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(ACK_TIMEOUT);
  localparam logic [PW-1:0] P_LAST   = PW'(BEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_WAIT,
    ST_FAULT
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;    // subsystem currently (or next) being polled
  logic [TW-1:0]   t_cnt;  // req-high cycles seen for the current request
  logic [PW-1:0]   p_cnt;  // edges elapsed since the last beat

  // Polling sequencer with all outputs registered.
  // NOTE: every assignment here is non-blocking so each branch reads the
  // pre-edge values of state, idx and the counters, exactly like flip-flops.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; it is not in the
    // sensitivity list, so synthesis builds it into the D-input logic.
    if (!rst) begin
      state    <= ST_IDLE;
      req      <= '0;
      beat     <= 1'b0;
      ok       <= 1'b0;
      fail     <= 1'b0;
      fail_idx <= '0;
      idx      <= '0;
      t_cnt    <= '0;
      p_cnt    <= '0;
    end else begin
      // NOTE: beat defaults low every cycle so it can only ever be a one-cycle
      // pulse; the branch that completes a round overrides it.
      beat <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          req <= '0;
          if (en) begin
            idx   <= '0;
            state <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (!en) begin
            state <= ST_IDLE;
            req   <= '0;
            ok    <= 1'b0;
            t_cnt <= '0;
            p_cnt <= '0;
          end else begin
            req   <= N_SUB'(1) << idx;
            t_cnt <= TW'(1);
            state <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (!en) begin
            // Disable wins over a simultaneous acknowledge.
            state <= ST_IDLE;
            req   <= '0;
            ok    <= 1'b0;
            t_cnt <= '0;
            p_cnt <= '0;
          end else if (ack[idx]) begin
            req   <= '0;
            t_cnt <= '0;
            if (idx == LAST_IDX) begin
              beat  <= 1'b1;
              ok    <= 1'b1;
              p_cnt <= '0;
              state <= ST_WAIT;
            end else begin
              idx   <= idx + IW'(1);
              state <= ST_GAP;
            end
          end else if (t_cnt == T_MAX) begin
            // The ACK_TIMEOUT-th cycle had its chance above; give up now.
            req      <= '0;
            ok       <= 1'b0;
            fail     <= 1'b1;
            fail_idx <= idx;
            state    <= ST_FAULT;
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        end

        ST_WAIT: begin
          if (!en) begin
            state <= ST_IDLE;
            req   <= '0;
            ok    <= 1'b0;
            t_cnt <= '0;
            p_cnt <= '0;
          end else if (p_cnt == P_LAST) begin
            idx   <= '0;
            req   <= N_SUB'(1);
            t_cnt <= TW'(1);
            p_cnt <= '0;
            state <= ST_REQ;
          end else begin
            p_cnt <= p_cnt + PW'(1);
          end
        end

        ST_FAULT: begin
          // Absorbing: everything holds until reset.
        end

        default: begin
          state <= ST_IDLE;
          req   <= '0;
          ok    <= 1'b0;
        end
      endcase
    end
  end

endmodule
